alsu_driver: RTL and testbench
==============================

Name: alsu_driver

Overview:
Command-side master for the ALSU datapath. It accepts one operation at a time on a valid/ready command port and drives the ALSU control/operand inputs for a programmed number of clock cycles. It then captures the ALSU's registered out/leds and returns them on a valid/ready response port. It sits between the test/host sequencer and the ALSU instance, in the same clock domain.

Parameters:
CYC_W, 4, width of cmd_cycles; hold length = cmd_cycles+1 drive cycles (1..2^CYC_W)
TAG_W, 4, width of the command tag echoed in the response

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  driver can accept a command (high only in IDLE)
cmd_a  input  3  operand A
cmd_b  input  3  operand B
cmd_opcode  input  3  ALSU opcode
cmd_flags  input  7  [0]cin [1]serialin [2]red_op_a [3]red_op_b [4]bypass_a [5]bypass_b [6]direction
cmd_cycles  input  CYC_W  drive cycles minus one
cmd_tag  input  TAG_W  opaque tag
alsu_a, alsu_b, alsu_opcode  output  3 each  to ALSU
alsu_cin, alsu_serialin, alsu_red_op_a, alsu_red_op_b, alsu_bypass_a, alsu_bypass_b, alsu_direction  output  1 each  to ALSU
alsu_out  input  6  ALSU registered result
alsu_leds  input  16  ALSU registered leds
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_out  output  6  captured alsu_out
rsp_leds  output  16  captured alsu_leds
rsp_tag  output  TAG_W  echoed cmd_tag

Behaviour:
- Reset is asynchronous and active-low. While rst=0: state IDLE, all alsu_* outputs at park value, rsp_valid=0, rsp_out=0, rsp_leds=0, rsp_tag=0, counter=0. cmd_ready=1 after release.
- All outputs are registered, except cmd_ready, which is a decode of the state register.
- Park value: alsu_a=0, alsu_b=0, alsu_opcode=0, all flags 0. A parked ALSU therefore loads out=0, leds=0 every edge.
- States:
  IDLE: alsu_* parked, cmd_ready=1. On cmd_valid at the edge: latch a/b/opcode/flags/tag, load counter=cmd_cycles, and load alsu_* with the command fields; go to DRIVE.
  DRIVE: alsu_* hold the command. Each edge with counter!=0 decrements the counter. At the edge with counter==0, park alsu_* and go to CAPTURE.
  CAPTURE: alsu_* parked. At the edge, load rsp_out<=alsu_out, rsp_leds<=alsu_leds, rsp_tag<=latched tag, rsp_valid<=1; go to RESP.
  RESP: all rsp_* are held stable while rsp_valid=1 and rsp_ready=0. On rsp_ready=1 at the edge: rsp_valid<=0; go to IDLE.
- Latency:
  - Accept edge E0. The ALSU sees the command for N=cmd_cycles+1 edges (E1..EN).
  - Capture happens at E(N+1), so rsp_valid is first high in the cycle after E(N+1).
  - Minimum command-to-command spacing is N+3 cycles when rsp_ready is tied high.
- Each command starts from ALSU out=0/leds=0, guaranteed by at least one parked edge (the CAPTURE edge, and the IDLE cycles after reset). Shift, rotate and blink results are therefore a pure function of (command, N).
- cmd_cycles at its maximum value (all ones) gives 2^CYC_W drive edges; the counter never wraps.
- cmd_valid outside IDLE is ignored. The command is not latched and must be held by the source until cmd_ready.
- rsp_ready outside RESP is ignored.
- Reset asserted mid-DRIVE/CAPTURE/RESP immediately returns to the reset values above. The in-flight command and any pending response are discarded, and no response is issued for them.
- Opcode values 6/7 are legal and are passed through unchanged; the driver performs no opcode checking.

Decomposition:
- Package alsu_drv_pkg holds:
  - the state encoding (IDLE, DRIVE, CAPTURE, RESP);
  - the flag bit index constants (FLG_CIN=0 .. FLG_DIR=6);
  - the park value constants.
- One natural sub-module: alsu_drv_cnt, a loadable CYC_W down-counter with a zero flag.
- FSM and output registers stay in alsu_driver.

Test Plan:
1. a=5,b=3,opcode=0,flags=0,cycles=0 against the real ALSU -> rsp_out=6'b000001, rsp_leds=0, rsp_valid high exactly 2 cycles after the first DRIVE cycle ends.
2. a=7,b=7,opcode=2,cin=1,cycles=0 -> rsp_out=6'd15. Then a=7,b=6,opcode=3 -> rsp_out=6'd42, tags echoed in order.
3. opcode=4,direction=1,serialin=1,cycles=2 -> alsu inputs held exactly 3 edges, rsp_out=6'b000111.
4. opcode=6: cycles=0 -> rsp_leds=16'hFFFF; cycles=1 -> rsp_leds=16'h0000. rsp_out=0 in both.
5. rsp_ready held low 5 cycles -> rsp_valid and rsp_* stable, cmd_ready=0, a second cmd_valid is not accepted until one cycle after the rsp handshake.
6. rst pulled low during DRIVE with cycles=15 -> all alsu_* parked, rsp_valid=0, no response emitted. After release, cmd_ready=1 and the next command completes normally.

Source files
------------

// File: rtl/alsu_drv_pkg.sv
// Shared definitions for the ALSU command driver: FSM state encoding,
// flag bit positions within cmd_flags and the parked ALSU drive value.
package alsu_drv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    // Bit positions inside cmd_flags
    localparam int FLG_CIN   = 0;
    localparam int FLG_SIN   = 1;
    localparam int FLG_RED_A = 2;
    localparam int FLG_RED_B = 3;
    localparam int FLG_BYP_A = 4;
    localparam int FLG_BYP_B = 5;
    localparam int FLG_DIR   = 6;
    localparam int FLG_W     = 7;

    // Everything the ALSU sees from the driver, bundled as one register
    typedef struct packed {
        logic [2:0]       a;
        logic [2:0]       b;
        logic [2:0]       opcode;
        logic [FLG_W-1:0] flags;
    } alsu_drive_t;

    // Park value: AND of zeros with no flags, so the ALSU loads out=0, leds=0
    localparam logic [2:0]       PARK_A      = 3'd0;
    localparam logic [2:0]       PARK_B      = 3'd0;
    localparam logic [2:0]       PARK_OPCODE = 3'd0;
    localparam logic [FLG_W-1:0] PARK_FLAGS  = '0;
    localparam alsu_drive_t      PARK_DRIVE  = '{a: PARK_A, b: PARK_B,
                                                 opcode: PARK_OPCODE,
                                                 flags: PARK_FLAGS};

endpackage

// File: rtl/alsu_drv_cnt.sv
// Loadable down-counter for the drive phase. Decrements saturate at zero
// so the counter can never wrap; zero flags the last drive edge.
module alsu_drv_cnt #(
    parameter int CYC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CYC_W-1:0] load_val,
    input  logic             dec,
    output logic [CYC_W-1:0] count,
    output logic             zero
);

    // Count register: load has priority, decrement stops at zero
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignment so every
        // register samples pre-edge values, independent of block order.
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/alsu_driver.sv
// Command-side master for the ALSU. Accepts one command, drives the ALSU
// inputs for cmd_cycles+1 edges, parks them for one edge, captures the
// registered ALSU result and returns it on a valid/ready response port.
module alsu_driver
    import alsu_drv_pkg::*;
#(
    parameter int CYC_W = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    // command port
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_a,
    input  logic [2:0]       cmd_b,
    input  logic [2:0]       cmd_opcode,
    input  logic [6:0]       cmd_flags,
    input  logic [CYC_W-1:0] cmd_cycles,
    input  logic [TAG_W-1:0] cmd_tag,
    // ALSU drive
    output logic [2:0]       alsu_a,
    output logic [2:0]       alsu_b,
    output logic [2:0]       alsu_opcode,
    output logic             alsu_cin,
    output logic             alsu_serialin,
    output logic             alsu_red_op_a,
    output logic             alsu_red_op_b,
    output logic             alsu_bypass_a,
    output logic             alsu_bypass_b,
    output logic             alsu_direction,
    // ALSU result
    input  logic [5:0]       alsu_out,
    input  logic [15:0]      alsu_leds,
    // response port
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [5:0]       rsp_out,
    output logic [15:0]      rsp_leds,
    output logic [TAG_W-1:0] rsp_tag
);

    state_t           state_q;
    state_t           state_d;
    alsu_drive_t      drive_q;
    logic [TAG_W-1:0] tag_q;
    logic [CYC_W-1:0] cnt_val;
    logic             cnt_zero;

    // Strobes decoded from the current state and handshakes
    logic accept;
    logic drive_done;
    logic capture;
    logic release_rsp;

    // Drive-length counter
    alsu_drv_cnt #(.CYC_W(CYC_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (cmd_cycles),
        .dec      (state_q == ST_DRIVE),
        .count    (cnt_val),
        .zero     (cnt_zero)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: assigning a default before the case keeps every path
        // assigned, so no latch is inferred for state_d.
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (cmd_valid) state_d = ST_DRIVE;
            ST_DRIVE:   if (cnt_zero)  state_d = ST_CAPTURE;
            ST_CAPTURE:                state_d = ST_RESP;
            ST_RESP:    if (rsp_ready) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // Output decode: cmd_ready and the register-update strobes
    always_comb begin
        cmd_ready   = (state_q == ST_IDLE);
        accept      = (state_q == ST_IDLE)    && cmd_valid;
        drive_done  = (state_q == ST_DRIVE)   && cnt_zero;
        capture     = (state_q == ST_CAPTURE);
        release_rsp = (state_q == ST_RESP)    && rsp_ready;
    end

    // Registered ALSU drive, latched tag and response outputs
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: only control and data output registers here; all of them
        // have a defined reset value because the reset state is visible.
        if (!rst) begin
            drive_q   <= PARK_DRIVE;
            tag_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_out   <= '0;
            rsp_leds  <= '0;
            rsp_tag   <= '0;
        end else begin
            if (accept) begin
                drive_q <= '{a: cmd_a, b: cmd_b, opcode: cmd_opcode,
                             flags: cmd_flags};
                tag_q   <= cmd_tag;
            end else if (drive_done) begin
                drive_q <= PARK_DRIVE;
            end

            if (capture) begin
                rsp_out   <= alsu_out;
                rsp_leds  <= alsu_leds;
                rsp_tag   <= tag_q;
                rsp_valid <= 1'b1;
            end else if (release_rsp) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign alsu_a         = drive_q.a;
    assign alsu_b         = drive_q.b;
    assign alsu_opcode    = drive_q.opcode;
    assign alsu_cin       = drive_q.flags[FLG_CIN];
    assign alsu_serialin  = drive_q.flags[FLG_SIN];
    assign alsu_red_op_a  = drive_q.flags[FLG_RED_A];
    assign alsu_red_op_b  = drive_q.flags[FLG_RED_B];
    assign alsu_bypass_a  = drive_q.flags[FLG_BYP_A];
    assign alsu_bypass_b  = drive_q.flags[FLG_BYP_B];
    assign alsu_direction = drive_q.flags[FLG_DIR];

endmodule

// File: tb/tb_alsu_driver.sv
// Directed bench for alsu_driver with a small behavioural ALSU whose
// out/leds registers load straight from the driver outputs each edge.
module tb_alsu_driver;

    localparam int CYC_W = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid, cmd_ready;
    logic [2:0]       cmd_a, cmd_b, cmd_opcode;
    logic [6:0]       cmd_flags;
    logic [CYC_W-1:0] cmd_cycles;
    logic [TAG_W-1:0] cmd_tag;
    logic [2:0]       alsu_a, alsu_b, alsu_opcode;
    logic             alsu_cin, alsu_serialin, alsu_red_op_a, alsu_red_op_b;
    logic             alsu_bypass_a, alsu_bypass_b, alsu_direction;
    logic [5:0]       alsu_out;
    logic [15:0]      alsu_leds;
    logic             rsp_valid, rsp_ready;
    logic [5:0]       rsp_out;
    logic [15:0]      rsp_leds;
    logic [TAG_W-1:0] rsp_tag;
    logic [6:0]       alsu_flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alsu_driver #(.CYC_W(CYC_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opcode(cmd_opcode),
        .cmd_flags(cmd_flags), .cmd_cycles(cmd_cycles), .cmd_tag(cmd_tag),
        .alsu_a(alsu_a), .alsu_b(alsu_b), .alsu_opcode(alsu_opcode),
        .alsu_cin(alsu_cin), .alsu_serialin(alsu_serialin),
        .alsu_red_op_a(alsu_red_op_a), .alsu_red_op_b(alsu_red_op_b),
        .alsu_bypass_a(alsu_bypass_a), .alsu_bypass_b(alsu_bypass_b),
        .alsu_direction(alsu_direction),
        .alsu_out(alsu_out), .alsu_leds(alsu_leds),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_leds(rsp_leds), .rsp_tag(rsp_tag)
    );

    assign alsu_flags = {alsu_direction, alsu_bypass_b, alsu_bypass_a,
                         alsu_red_op_b, alsu_red_op_a, alsu_serialin, alsu_cin};

    // Behavioural ALSU: registered out/leds loaded from the driver each edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alsu_out  <= '0;
            alsu_leds <= '0;
        end else if (alsu_bypass_a) begin
            alsu_out  <= {3'b0, alsu_a};
            alsu_leds <= '0;
        end else begin
            alsu_leds <= '0;
            case (alsu_opcode)
                3'd0: alsu_out <= {3'b0, alsu_a & alsu_b};
                3'd1: alsu_out <= {3'b0, alsu_a ^ alsu_b};
                3'd2: alsu_out <= {3'b0, alsu_a} + {3'b0, alsu_b} + {5'b0, alsu_cin};
                3'd3: alsu_out <= {3'b0, alsu_a} * {3'b0, alsu_b};
                3'd4: alsu_out <= alsu_direction ? {alsu_out[4:0], alsu_serialin}
                                                 : {alsu_serialin, alsu_out[5:1]};
                3'd5: alsu_out <= alsu_direction ? {alsu_out[4:0], alsu_out[5]}
                                                 : {alsu_out[0], alsu_out[5:1]};
                default: begin
                    alsu_out  <= '0;
                    alsu_leds <= ~alsu_leds;
                end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and hold it until the accept edge has passed
    task automatic send(input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] op, input logic [6:0] fl,
                        input logic [3:0] cyc, input logic [3:0] tag);
        int n = 0;
        cmd_a = a; cmd_b = b; cmd_opcode = op; cmd_flags = fl;
        cmd_cycles = cyc; cmd_tag = tag; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        check("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Called just after the accept edge: checks hold length, latency,
    // response contents, back-pressure stability and the handshake.
    task automatic collect(input string name, input logic [5:0] exp_out,
                           input logic [15:0] exp_leds, input logic [3:0] exp_tag,
                           input int n_drive, input int stall, input bit poke);
        int n = 0;
        int held = 0;
        while (!rsp_valid && n < 60) begin
            if (alsu_a == cmd_a && alsu_b == cmd_b && alsu_opcode == cmd_opcode
                && alsu_flags == cmd_flags)
                held++;
            tick();
            n++;
        end
        check({name, "_latency"}, 32'(n), 32'(n_drive + 1));
        check({name, "_held_edges"}, 32'(held), 32'(n_drive));
        check({name, "_parked_in_resp"}, 32'(alsu_opcode), 32'd0);
        check({name, "_cmd_ready_in_resp"}, 32'(cmd_ready), 32'd0);
        if (poke) cmd_valid = 1'b1;
        for (int i = 0; i < stall; i++) begin
            tick();
            check({name, "_stall_valid"}, 32'(rsp_valid), 32'd1);
            check({name, "_stall_out"}, 32'(rsp_out), 32'(exp_out));
            check({name, "_stall_leds"}, 32'(rsp_leds), 32'(exp_leds));
            check({name, "_stall_ready"}, 32'(cmd_ready), 32'd0);
            check({name, "_stall_no_accept"}, 32'(alsu_a), 32'd0);
        end
        check({name, "_out"}, 32'(rsp_out), 32'(exp_out));
        check({name, "_leds"}, 32'(rsp_leds), 32'(exp_leds));
        check({name, "_tag"}, 32'(rsp_tag), 32'(exp_tag));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({name, "_valid_dropped"}, 32'(rsp_valid), 32'd0);
        check({name, "_cmd_ready_after"}, 32'(cmd_ready), 32'd1);
        check({name, "_not_yet_accepted"}, 32'(alsu_opcode), 32'd0);
    endtask

    initial begin
        int seen;
        rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_opcode = '0; cmd_flags = '0;
        cmd_cycles = '0; cmd_tag = '0;
        #2;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_out", 32'(rsp_out), 32'd0);
        check("rst_rsp_leds", 32'(rsp_leds), 32'd0);
        check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        check("rst_alsu_park", 32'({alsu_a, alsu_b, alsu_opcode, alsu_flags}), 32'd0);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

        // 1: AND 5&3 = 1, one drive edge
        send(3'd5, 3'd3, 3'd0, 7'b0000000, 4'd0, 4'h1);
        collect("and", 6'd1, 16'h0000, 4'h1, 1, 0, 1'b0);

        // 2: add with carry then multiply, tags in order
        send(3'd7, 3'd7, 3'd2, 7'b0000001, 4'd0, 4'h2);
        collect("add", 6'd15, 16'h0000, 4'h2, 1, 0, 1'b0);
        send(3'd7, 3'd6, 3'd3, 7'b0000000, 4'd0, 4'h3);
        collect("mul", 6'd42, 16'h0000, 4'h3, 1, 0, 1'b0);

        // 3: shift left with serialin=1 for 3 edges -> 000111
        send(3'd1, 3'd2, 3'd4, 7'b1000010, 4'd2, 4'h4);
        collect("shl", 6'b000111, 16'h0000, 4'h4, 3, 0, 1'b0);

        // 4: invalid opcode blinks leds once per drive edge
        send(3'd1, 3'd1, 3'd6, 7'b0000000, 4'd0, 4'h5);
        collect("blink1", 6'd0, 16'hFFFF, 4'h5, 1, 0, 1'b0);
        send(3'd1, 3'd1, 3'd6, 7'b0000000, 4'd1, 4'h6);
        collect("blink2", 6'd0, 16'h0000, 4'h6, 2, 0, 1'b0);

        // 5: back-pressure for 5 cycles with a competing cmd_valid
        send(3'd6, 3'd3, 3'd1, 7'b0000000, 4'd0, 4'h7);
        collect("stall", 6'd5, 16'h0000, 4'h7, 1, 5, 1'b1);
        send(3'd3, 3'd2, 3'd2, 7'b0000000, 4'd3, 4'h8);
        collect("after_stall", 6'd5, 16'h0000, 4'h8, 4, 0, 1'b0);

        // Maximum drive length: 16 edges, counter must not wrap
        send(3'd2, 3'd1, 3'd5, 7'b1010000, 4'd15, 4'h9);
        collect("max_len", 6'd2, 16'h0000, 4'h9, 16, 0, 1'b0);

        // 6: reset during DRIVE discards the command
        send(3'd4, 3'd5, 3'd2, 7'b0000001, 4'd15, 4'hA);
        repeat (4) tick();
        check("mid_drive_opcode", 32'(alsu_opcode), 32'd2);
        rst = 1'b0;
        #2;
        check("mid_rst_park", 32'({alsu_a, alsu_b, alsu_opcode, alsu_flags}), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (rsp_valid) seen++;
        end
        check("no_rsp_after_rst", 32'(seen), 32'd0);
        check("cmd_ready_after_mid_rst", 32'(cmd_ready), 32'd1);
        send(3'd3, 3'd3, 3'd2, 7'b0000001, 4'd0, 4'hB);
        collect("post_rst", 6'd7, 16'h0000, 4'hB, 1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
